// File: rtl/brightness_level_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : brightness_level_controller_pkg
//  Brief    : Shared types and constants for the brightness level controller:
//             debounce FSM encoding, default maximum shift, pixel shift helper.
//  Revision : 1.0 - initial release
// ============================================================================
package brightness_level_controller_pkg;

    // Debounce FSM state encoding (2 bits)
    typedef enum logic [1:0] {
        DB_STABLE_LOW  = 2'b00,
        DB_WAIT_HIGH   = 2'b01,
        DB_STABLE_HIGH = 2'b10,
        DB_WAIT_LOW    = 2'b11
    } db_state_t;

    // At this shift level every 4-bit channel is fully blanked
    localparam int c_DEFAULT_MAX_SHIFT = 4;

    // Shift each RGB444 channel right by lvl; shifting 4 bits by >= 4 yields 0
    function automatic logic [11:0] shift_pixel(input logic [11:0] px,
                                                input logic [2:0]  lvl);
        logic [3:0] r_ch;
        logic [3:0] g_ch;
        logic [3:0] b_ch;
        r_ch = px[11:8] >> lvl;
        g_ch = px[7:4]  >> lvl;
        b_ch = px[3:0]  >> lvl;
        return {r_ch, g_ch, b_ch};
    endfunction

endpackage : brightness_level_controller_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Brief    : 2-flop synchronizer plus 4-state debounce FSM for one raw button.
//             Emits a single-cycle press pulse on each accepted press.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
    import brightness_level_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    db_state_t          r_state;
    db_state_t          w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               r_press;
    logic               w_press_next;
    logic               w_in;

    assign w_in  = r_sync[1];
    assign press = r_press;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= 2'b00;
        else     r_sync <= {r_sync[0], raw};
    end

    // FSM state, stability counter and registered press pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DB_STABLE_LOW;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_press <= w_press_next;
        end
    end

    // Next-state logic: the count restarts on every direction change
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_press_next = 1'b0;
        case (r_state)
            DB_STABLE_LOW: begin
                w_cnt_next = '0;
                if (w_in) w_state_next = DB_WAIT_HIGH;
            end
            DB_WAIT_HIGH: begin
                if (!w_in) begin
                    w_state_next = DB_STABLE_LOW;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next = DB_STABLE_HIGH;
                    w_cnt_next   = '0;
                    w_press_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
            DB_STABLE_HIGH: begin
                w_cnt_next = '0;
                if (!w_in) w_state_next = DB_WAIT_LOW;
            end
            DB_WAIT_LOW: begin
                if (w_in) begin
                    w_state_next = DB_STABLE_HIGH;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next = DB_STABLE_LOW;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_next = DB_STABLE_LOW;
                w_cnt_next   = '0;
            end
        endcase
    end

endmodule : btn_debounce
`default_nettype wire

// File: rtl/brightness_level_controller.sv
`default_nettype none
// ============================================================================
//  Module   : brightness_level_controller
//  Brief    : Debounced up/down buttons select a shift level that is applied
//             to an RGB444 pixel stream at frame boundaries (vsync rise).
//  Revision : 1.0 - initial release
// ============================================================================
module brightness_level_controller
    import brightness_level_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_SHIFT       = c_DEFAULT_MAX_SHIFT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        vsync,
    input  logic [11:0] pixel_in,
    input  logic        pixel_in_valid,
    output logic [11:0] pixel_out,
    output logic        pixel_out_valid,
    output logic [2:0]  shift_level,
    output logic        level_pending
);

    localparam logic [2:0] c_MAX_LEVEL = 3'(MAX_SHIFT);

    logic        w_press_up;
    logic        w_press_down;
    logic        w_vsync_rise;
    logic        r_vsync_d;
    logic [2:0]  r_pending;
    logic [2:0]  r_active;
    logic [11:0] r_pixel_out;
    logic        r_pixel_valid;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_up (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_up),
        .press (w_press_up)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_down (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_down),
        .press (w_press_down)
    );

    assign w_vsync_rise    = vsync && !r_vsync_d;
    assign shift_level     = r_active;
    assign level_pending   = (r_pending != r_active);
    assign pixel_out       = r_pixel_out;
    assign pixel_out_valid = r_pixel_valid;

    // Remember last vsync for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_vsync_d <= 1'b0;
        else     r_vsync_d <= vsync;
    end

    // Requested level: saturating up/down, simultaneous presses cancel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 3'd0;
        end else if (w_press_up && !w_press_down) begin
            if (r_pending != 3'd0) r_pending <= r_pending - 3'd1;
        end else if (w_press_down && !w_press_up) begin
            if (r_pending < c_MAX_LEVEL) r_pending <= r_pending + 3'd1;
        end
    end

    // Active level follows the pre-edge pending value only at frame boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_active <= 3'd0;
        else if (w_vsync_rise) r_active <= r_pending;
    end

    // One-cycle pixel pipeline using the level in force before this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pixel_out   <= 12'h000;
            r_pixel_valid <= 1'b0;
        end else begin
            r_pixel_valid <= pixel_in_valid;
            if (pixel_in_valid) r_pixel_out <= shift_pixel(pixel_in, r_active);
        end
    end

endmodule : brightness_level_controller
`default_nettype wire
